// File: rtl/message_printer_pkg.sv
// printer_pkg: shared definitions for the message_printer sequencer.
// Holds the FSM state encoding, the ASCII constants used when talking to
// message_rom / uart_tx, the fixed ROM settle time and a small helper that
// decides whether a ROM byte is a suppressible leading zero.
package printer_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONVERT  = 3'd1,
    ROM_WAIT = 3'd2,
    DECIDE   = 3'd3,
    SEND     = 3'd4,
    TX_HOLD  = 3'd5,
    FINISH   = 3'd6
  } state_t;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_NL   = 8'h0A;

  // Cycles between an address change and a valid rom_data sample:
  // one for message_rom's state register, one for its registered output.
  localparam int ROM_WAIT_CYCLES = 2;

  // A byte is dropped only while no significant digit has been seen yet and
  // it is not the least significant digit (address 1), so "0" still prints.
  function automatic logic skip_lead_zero(input logic       suppress,
                                          input logic [7:0] rom_byte,
                                          input logic       nonzero_seen,
                                          input logic       addr_above_one);
    skip_lead_zero = suppress && (rom_byte == CHAR_ZERO) && !nonzero_seen && addr_above_one;
  endfunction

endpackage

// File: rtl/message_printer.sv
// message_printer: sequencer between message_rom and uart_tx.
// A print request latches a 32-bit value, runs the ROM conversion, then walks
// the ROM address from the most significant digit down to 0 ("\n"), handing
// each byte to uart_tx under busy backpressure. Leading zeros are optionally
// dropped. All outputs are registered.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, value    print request (accepted only when idle) and value to print
//   busy, done      in-progress flag, one-cycle completion pulse
//   rom_addr        message_rom address
//   rom_data        message_rom data (registered there, 1-cycle latency)
//   rom_value       latched value driven to message_rom valuetoprint
//   rom_startconv   message_rom startconv
//   rom_convdone    message_rom conversiondone
//   tx_data         byte to uart_tx
//   new_tx_data     one-cycle strobe to uart_tx
//   tx_busy         uart_tx busy
module message_printer
  import printer_pkg::*;
#(
  parameter int NUM_DIGITS     = 10,
  parameter int ADDR_WIDTH     = 8,
  parameter int SUPPRESS_ZEROS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [31:0]           rom_value,
  output logic                  rom_startconv,
  input  logic                  rom_convdone,
  output logic [7:0]            tx_data,
  output logic                  new_tx_data,
  input  logic                  tx_busy
);

  localparam int WAIT_W = (ROM_WAIT_CYCLES > 1) ? $clog2(ROM_WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(ROM_WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0]     WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = ADDR_WIDTH'(NUM_DIGITS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic                  SUPPRESS  = (SUPPRESS_ZEROS != 0);

  state_t                  state_r;
  state_t                  state_s;
  logic [WAIT_W-1:0]       wait_cnt_r;
  logic [WAIT_W-1:0]       wait_cnt_s;
  logic [7:0]              rom_byte_r;
  logic [7:0]              rom_byte_s;
  logic                    nonzero_seen_r;
  logic                    nonzero_seen_s;
  logic [ADDR_WIDTH-1:0]   rom_addr_s;
  logic [31:0]             rom_value_s;
  logic                    rom_startconv_s;
  logic [7:0]              tx_data_s;
  logic                    new_tx_data_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    skip_s;

  assign skip_s = skip_lead_zero(SUPPRESS, rom_byte_r, nonzero_seen_r, (rom_addr > ADDR_ONE));

  // State, datapath and output registers; reset aborts any print in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      wait_cnt_r     <= WAIT_ZERO;
      rom_byte_r     <= 8'h00;
      nonzero_seen_r <= 1'b0;
      rom_addr       <= ADDR_TOP;
      rom_value      <= 32'h0000_0000;
      rom_startconv  <= 1'b0;
      tx_data        <= 8'h00;
      new_tx_data    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_r        <= state_s;
      wait_cnt_r     <= wait_cnt_s;
      rom_byte_r     <= rom_byte_s;
      nonzero_seen_r <= nonzero_seen_s;
      rom_addr       <= rom_addr_s;
      rom_value      <= rom_value_s;
      rom_startconv  <= rom_startconv_s;
      tx_data        <= tx_data_s;
      new_tx_data    <= new_tx_data_s;
      busy           <= busy_s;
      done           <= done_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        // busy is still high in the cycle done pulses, so a start there is dropped
        if (start && !busy) state_s = CONVERT;
        else                state_s = IDLE;
      end
      CONVERT: begin
        if (rom_convdone) state_s = ROM_WAIT;
        else              state_s = CONVERT;
      end
      ROM_WAIT: begin
        if (wait_cnt_r == WAIT_ZERO) state_s = DECIDE;
        else                         state_s = ROM_WAIT;
      end
      DECIDE: begin
        if (skip_s) state_s = ROM_WAIT;
        else        state_s = SEND;
      end
      SEND: begin
        if (!tx_busy) state_s = TX_HOLD;
        else          state_s = SEND;
      end
      TX_HOLD: begin
        // address 0 carries the "\n", so the walk ends there without wrapping
        if (rom_addr == ADDR_ZERO) state_s = FINISH;
        else                       state_s = ROM_WAIT;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath registers.
  always_comb begin
    wait_cnt_s      = wait_cnt_r;
    rom_byte_s      = rom_byte_r;
    nonzero_seen_s  = nonzero_seen_r;
    rom_addr_s      = rom_addr;
    rom_value_s     = rom_value;
    rom_startconv_s = rom_startconv;
    tx_data_s       = tx_data;
    new_tx_data_s   = 1'b0;
    busy_s          = busy;
    done_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !busy) begin
          rom_value_s     = value;
          rom_startconv_s = 1'b1;
          busy_s          = 1'b1;
          nonzero_seen_s  = 1'b0;
        end else begin
          busy_s = 1'b0;
        end
      end
      CONVERT: begin
        // startconv must fall on the same edge that sees conversiondone,
        // otherwise message_rom restarts its conversion
        if (rom_convdone) begin
          rom_startconv_s = 1'b0;
          rom_addr_s      = ADDR_TOP;
          wait_cnt_s      = WAIT_LOAD;
        end else begin
          rom_startconv_s = 1'b1;
        end
      end
      ROM_WAIT: begin
        if (wait_cnt_r == WAIT_ZERO) rom_byte_s = rom_data;
        else                         wait_cnt_s = wait_cnt_r - WAIT_W'(1);
      end
      DECIDE: begin
        if (skip_s) begin
          rom_addr_s = rom_addr - ADDR_ONE;
          wait_cnt_s = WAIT_LOAD;
        end else begin
          tx_data_s      = rom_byte_r;
          nonzero_seen_s = 1'b1;
        end
      end
      SEND: begin
        if (!tx_busy) new_tx_data_s = 1'b1;
        else          new_tx_data_s = 1'b0;
      end
      TX_HOLD: begin
        // one dead cycle lets uart_tx raise busy before we look at it again
        if (rom_addr != ADDR_ZERO) begin
          rom_addr_s = rom_addr - ADDR_ONE;
          wait_cnt_s = WAIT_LOAD;
        end else begin
          rom_addr_s = rom_addr;
        end
      end
      FINISH: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_message_printer.sv
// Self-checking bench for message_printer. Two instances run side by side:
// index 0 suppresses leading zeros, index 1 prints all digits. Behavioural
// models of message_rom (1-cycle registered data, variable conversion time,
// stray conversiondone pulses) and uart_tx (configurable busy time) drive
// the inputs on the falling edge; received bytes are compared with the
// decimal text of the value built from $sformatf.
module tb_message_printer;

  localparam int ND = 10;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          start_v      [2];
  logic [31:0]   value_v      [2];
  logic          busy_v       [2];
  logic          done_v       [2];
  logic [AW-1:0] rom_addr_v   [2];
  logic [7:0]    rom_data_v   [2];
  logic [31:0]   rom_value_v  [2];
  logic          startconv_v  [2];
  logic          convdone_v   [2];
  logic [7:0]    tx_data_v    [2];
  logic          new_tx_v     [2];
  logic          tx_busy_v    [2];

  int            n_cmp;
  int            n_err;

  int            busy_len  [2];
  int            busy_cnt  [2];
  int            conv_len  [2];
  int            conv_cnt  [2];
  bit            conv_real [2];
  logic [AW-1:0] addr_prev [2];
  logic [7:0]    rx        [2][64];
  int            rx_n      [2];
  int            done_cnt  [2];
  logic [7:0]    hist      [2][30];
  bit            stall_chk;

  message_printer #(.NUM_DIGITS(ND), .ADDR_WIDTH(AW), .SUPPRESS_ZEROS(1)) u_sup (
    .clk(clk), .rst(rst), .start(start_v[0]), .value(value_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rom_addr(rom_addr_v[0]),
    .rom_data(rom_data_v[0]), .rom_value(rom_value_v[0]),
    .rom_startconv(startconv_v[0]), .rom_convdone(convdone_v[0]),
    .tx_data(tx_data_v[0]), .new_tx_data(new_tx_v[0]), .tx_busy(tx_busy_v[0])
  );

  message_printer #(.NUM_DIGITS(ND), .ADDR_WIDTH(AW), .SUPPRESS_ZEROS(0)) u_full (
    .clk(clk), .rst(rst), .start(start_v[1]), .value(value_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rom_addr(rom_addr_v[1]),
    .rom_data(rom_data_v[1]), .rom_value(rom_value_v[1]),
    .rom_startconv(startconv_v[1]), .rom_convdone(convdone_v[1]),
    .tx_data(tx_data_v[1]), .new_tx_data(new_tx_v[1]), .tx_busy(tx_busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimal text of v, zero padded to ND digits when requested.
  function automatic string dec_text(input bit full, input logic [31:0] v);
    string s;
    s = $sformatf("%0d", v);
    while (full && s.len() < ND) s = {"0", s};
    return s;
  endfunction

  function automatic string exp_str(input bit full, input logic [31:0] v);
    return {dec_text(full, v), "\n"};
  endfunction

  // message_rom content: address a (1..ND) holds digit of weight 10^(a-1).
  function automatic logic [7:0] rom_byte(input logic [31:0] v, input logic [AW-1:0] a);
    string s;
    s = dec_text(1'b1, v);
    if (a == 0)       return 8'h0A;
    else if (a <= ND) return s[ND - int'(a)];
    else              return 8'h3F;
  endfunction

  // Upstream/downstream models and monitors, all on the falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (new_tx_v[c]) begin
        chk("strobe_while_busy", tx_busy_v[c], 1'b0);
        if (rx_n[c] < 64) rx[c][rx_n[c]] = tx_data_v[c];
        rx_n[c]++;
        busy_cnt[c] = busy_len[c];
      end else if (busy_cnt[c] > 0) begin
        if (busy_cnt[c] == 1 && stall_chk) begin
          int bad;
          bad = 0;
          for (int j = 0; j < 30; j++) if (hist[c][j] !== tx_data_v[c]) bad++;
          chk("stall_tx_data_stable", bad, 0);
        end
        busy_cnt[c]--;
      end
      tx_busy_v[c] = (busy_cnt[c] > 0);
      for (int j = 29; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = tx_data_v[c];
      if (done_v[c] === 1'b1) done_cnt[c]++;

      rom_data_v[c] = rom_byte(rom_value_v[c], addr_prev[c]);
      addr_prev[c]  = rom_addr_v[c];

      if (convdone_v[c]) begin
        if (conv_real[c]) chk("startconv_drop", startconv_v[c], 1'b0);
        convdone_v[c] = 1'b0;
        conv_real[c]  = 1'b0;
        conv_cnt[c]   = 0;
      end else if (startconv_v[c]) begin
        conv_cnt[c]++;
        if (conv_cnt[c] >= conv_len[c]) begin
          convdone_v[c] = 1'b1;
          conv_real[c]  = 1'b1;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        convdone_v[c] = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input int c, input string tag);
    chk({tag, "_rom_addr"},  rom_addr_v[c],  32'd10);
    chk({tag, "_rom_value"}, rom_value_v[c], 32'd0);
    chk({tag, "_startconv"}, startconv_v[c], 32'd0);
    chk({tag, "_tx_data"},   tx_data_v[c],   32'd0);
    chk({tag, "_new_tx"},    new_tx_v[c],    32'd0);
    chk({tag, "_busy"},      busy_v[c],      32'd0);
    chk({tag, "_done"},      done_v[c],      32'd0);
  endtask

  task automatic run_print(input int c, input logic [31:0] v, input int blen, input bit mid);
    string e;
    bit    seen;
    int    n;
    e = exp_str(c == 1, v);
    busy_len[c] = blen;
    conv_len[c] = $urandom_range(1, 8);
    @(negedge clk);
    rx_n[c]     = 0;
    done_cnt[c] = 0;
    start_v[c]  = 1'b1;
    value_v[c]  = v;
    @(negedge clk);
    start_v[c]  = 1'b0;
    value_v[c]  = $urandom;
    chk("busy_on_accept", busy_v[c], 1'b1);
    chk("rom_value_latch", rom_value_v[c], v);
    seen = 1'b0;
    for (int k = 0; k < 8000 && !seen; k++) begin
      @(negedge clk);
      if (mid && k == 20) begin
        start_v[c] = 1'b1;
        value_v[c] = 32'd99;
      end else begin
        start_v[c] = 1'b0;
      end
      if (done_v[c] === 1'b1) seen = 1'b1;
    end
    start_v[c] = 1'b0;
    chk("done_seen", seen, 1'b1);
    @(negedge clk);
    chk("busy_after_done", busy_v[c], 1'b0);
    chk("done_one_cycle", done_v[c], 1'b0);
    chk("done_count", done_cnt[c], 1);
    n = rx_n[c];
    chk("byte_count", n, e.len());
    for (int i = 0; i < n && i < e.len() && i < 64; i++) chk("byte", rx[c][i], e[i]);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int            c;
    int            kind;
    logic [31:0]   v;
    bit            got3;
    n_cmp = 0;
    n_err = 0;
    stall_chk = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;   value_v[i] = 32'd0;   rom_data_v[i] = 8'h00;
      convdone_v[i] = 1'b0; tx_busy_v[i] = 1'b0; busy_len[i] = 0;
      busy_cnt[i] = 0;     conv_len[i] = 3;      conv_cnt[i] = 0;
      conv_real[i] = 1'b0; addr_prev[i] = '0;    rx_n[i] = 0;
      done_cnt[i] = 0;
      for (int j = 0; j < 30; j++) hist[i][j] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "reset_sup");
    check_reset_outputs(1, "reset_full");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_print(0, 32'd1234, 10, 1'b0);
    run_print(0, 32'd0, 10, 1'b0);
    run_print(1, 32'hFFFF_FFFF, 10, 1'b0);
    run_print(1, 32'd7, 4, 1'b0);

    stall_chk = 1'b1;
    run_print(0, 32'd4567, 60, 1'b0);
    repeat (70) @(negedge clk);
    stall_chk = 1'b0;

    run_print(0, 32'd123456, 10, 1'b1);
    run_print(1, 32'd80500, 2, 1'b1);

    // Reset while the third byte is stalled in SEND.
    busy_len[0] = 40;
    conv_len[0] = 2;
    rx_n[0]     = 0;
    done_cnt[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    value_v[0] = 32'd987654321;
    @(negedge clk);
    start_v[0] = 1'b0;
    got3 = 1'b0;
    for (int k = 0; k < 3000 && !got3; k++) begin
      @(negedge clk);
      if (rx_n[0] >= 2) got3 = 1'b1;
    end
    chk("reach_third_byte", got3, 1'b1);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs(0, "midprint_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_strobe_after_reset", rx_n[0], 2);
    chk("no_done_after_reset", done_cnt[0], 0);
    run_print(0, 32'd5, 3, 1'b0);

    for (int r = 0; r < 16; r++) begin
      c = r % 2;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 999);
        2:       v = 32'd0;
        default: v = $urandom_range(0, 9) * 32'd100000;
      endcase
      run_print(c, v, $urandom_range(0, 12), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
